// File: rtl/quad_enc_sampler_if.sv
// Snapshot handshake between the quadrature sampling controller and its consumer.
// The master presents position, delta and fault; the slave accepts with sample_ready.
interface quad_enc_sampler_if #(
    parameter int COUNT_W = 32
);
    logic               sample_valid;
    logic               sample_ready;
    logic [COUNT_W-1:0] sample_pos;
    logic [COUNT_W-1:0] sample_delta;
    logic               sample_fault;

    modport master (
        output sample_valid,
        output sample_pos,
        output sample_delta,
        output sample_fault,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  sample_pos,
        input  sample_delta,
        input  sample_fault,
        output sample_ready
    );
endinterface

// File: rtl/quad_enc_sampler.sv
// Periodic sampling controller for a quadrature decoder: owns the decoder reset,
// services clear requests and emits position/velocity/fault snapshots every period+1 clocks.
module quad_enc_sampler #(
    parameter int COUNT_W      = 32,
    parameter int PERIOD_W     = 16,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic                clear_req,
    output logic                clear_ack,
    input  logic [COUNT_W-1:0]  enc_count,
    input  logic                enc_faultn,
    output logic                enc_resetn,
    quad_enc_sampler_if.master  smp,
    output logic                overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          clr_cnt_q, clr_cnt_d;
    logic                ack_pend_q, ack_pend_d;
    logic                clear_ack_q, clear_ack_d;
    logic                enc_resetn_q, enc_resetn_d;
    logic [PERIOD_W-1:0] timer_q, timer_d;
    logic [COUNT_W-1:0]  prev_pos_q, prev_pos_d;
    logic                valid_q, valid_d;
    logic [COUNT_W-1:0]  pos_q, pos_d;
    logic [COUNT_W-1:0]  delta_q, delta_d;
    logic                fault_q, fault_d;
    logic                overrun_q, overrun_d;
    logic                accept;
    logic signed [COUNT_W-1:0] delta_now;

    // Velocity is the modular count difference, read as two's complement.
    function automatic logic signed [COUNT_W-1:0] wrap_delta(
        input logic [COUNT_W-1:0] cur,
        input logic [COUNT_W-1:0] prev
    );
        return $signed(cur - prev);
    endfunction

    assign accept    = valid_q & smp.sample_ready;
    assign delta_now = wrap_delta(enc_count, prev_pos_q);

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        ack_pend_d   = ack_pend_q;
        clear_ack_d  = 1'b0;
        enc_resetn_d = enc_resetn_q;
        timer_d      = timer_q;
        prev_pos_d   = prev_pos_q;
        valid_d      = valid_q;
        pos_d        = pos_q;
        delta_d      = delta_q;
        fault_d      = fault_q;
        overrun_d    = overrun_q;

        if (accept) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d      = CLEAR;
                    clr_cnt_d    = 4'(CLEAR_CYCLES);
                    ack_pend_d   = 1'b1;
                    enc_resetn_d = 1'b0;
                    overrun_d    = 1'b0;
                end else if (enable) begin
                    state_d = RUN;
                    timer_d = period;
                end
            end

            CLEAR: begin
                if (clr_cnt_q > 4'd1) begin
                    clr_cnt_d = clr_cnt_q - 4'd1;
                end else begin
                    enc_resetn_d = 1'b1;
                    clear_ack_d  = ack_pend_q;
                    ack_pend_d   = 1'b0;
                    prev_pos_d   = '0;
                    if (enable) begin
                        state_d = RUN;
                        timer_d = period;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            RUN: begin
                if (timer_q == '0) begin
                    timer_d = period;
                    // A held snapshot keeps prev_pos, so the next delta spans the dropped intervals.
                    if (!valid_q || accept) begin
                        valid_d    = 1'b1;
                        pos_d      = enc_count;
                        delta_d    = $unsigned(delta_now);
                        fault_d    = ~enc_faultn;
                        prev_pos_d = enc_count;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - PERIOD_W'(1);
                end

                if (clear_req) begin
                    state_d      = CLEAR;
                    clr_cnt_d    = 4'(CLEAR_CYCLES);
                    ack_pend_d   = 1'b1;
                    enc_resetn_d = 1'b0;
                    overrun_d    = 1'b0;
                end else if (!enable) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= CLEAR;
            clr_cnt_q    <= 4'(CLEAR_CYCLES);
            ack_pend_q   <= 1'b0;
            clear_ack_q  <= 1'b0;
            enc_resetn_q <= 1'b0;
            timer_q      <= '0;
            prev_pos_q   <= '0;
            valid_q      <= 1'b0;
            pos_q        <= '0;
            delta_q      <= '0;
            fault_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            ack_pend_q   <= ack_pend_d;
            clear_ack_q  <= clear_ack_d;
            enc_resetn_q <= enc_resetn_d;
            timer_q      <= timer_d;
            prev_pos_q   <= prev_pos_d;
            valid_q      <= valid_d;
            pos_q        <= pos_d;
            delta_q      <= delta_d;
            fault_q      <= fault_d;
            overrun_q    <= overrun_d;
        end
    end

    assign clear_ack        = clear_ack_q;
    assign enc_resetn       = enc_resetn_q;
    assign overrun          = overrun_q;
    assign smp.sample_valid = valid_q;
    assign smp.sample_pos   = pos_q;
    assign smp.sample_delta = delta_q;
    assign smp.sample_fault = fault_q;

endmodule

// File: tb/tb_quad_enc_sampler.sv
// Directed bench for quad_enc_sampler: the bench plays the decoder and the consumer,
// queueing expected snapshots as counts are driven and comparing them when they appear.
module tb_quad_enc_sampler;

    localparam int COUNT_W  = 32;
    localparam int PERIOD_W = 16;

    logic                clk;
    logic                resetn;
    logic                enable;
    logic [PERIOD_W-1:0] period;
    logic                clear_req;
    logic                clear_ack;
    logic [COUNT_W-1:0]  enc_count;
    logic                enc_faultn;
    logic                enc_resetn;
    logic                overrun;

    quad_enc_sampler_if #(.COUNT_W(COUNT_W)) smp ();

    quad_enc_sampler #(
        .COUNT_W     (COUNT_W),
        .PERIOD_W    (PERIOD_W),
        .CLEAR_CYCLES(2)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .period    (period),
        .clear_req (clear_req),
        .clear_ack (clear_ack),
        .enc_count (enc_count),
        .enc_faultn(enc_faultn),
        .enc_resetn(enc_resetn),
        .smp       (smp),
        .overrun   (overrun)
    );

    typedef struct {
        logic [COUNT_W-1:0] pos;
        logic [COUNT_W-1:0] delta;
        logic               fault;
    } snap_t;

    snap_t              sb[$];
    logic [COUNT_W-1:0] model_prev;
    int                 total;
    int                 bad;
    int                 n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time exceeded, required summary before 200000");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [COUNT_W-1:0] pos, input logic fault);
        snap_t s;
        s.pos      = pos;
        s.delta    = pos - model_prev;
        s.fault    = fault;
        model_prev = pos;
        sb.push_back(s);
    endtask

    task automatic pop_cmp(input string tag);
        snap_t s;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_sb_empty: observed=valid expected=queued snapshot", tag);
        end else begin
            s = sb.pop_front();
            check({tag, "_valid"}, 64'(smp.sample_valid), 64'(1));
            check({tag, "_pos"},   64'(smp.sample_pos),   64'(s.pos));
            check({tag, "_delta"}, 64'(smp.sample_delta), 64'(s.delta));
            check({tag, "_fault"}, 64'(smp.sample_fault), 64'(s.fault));
        end
    endtask

    // Advance at least one cycle, then until sample_valid is seen (bounded).
    task automatic next_sample(input int max, output int cnt);
        tick();
        cnt = 1;
        while (!smp.sample_valid && cnt < max) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        model_prev       = '0;
        resetn           = 1'b0;
        enable           = 1'b0;
        period           = 16'd9;
        clear_req        = 1'b0;
        enc_count        = '0;
        enc_faultn       = 1'b1;
        smp.sample_ready = 1'b0;

        // Reset and the reset-initiated clear
        repeat (3) tick();
        check("rst_enc_resetn", 64'(enc_resetn), 64'(0));
        check("rst_valid", 64'(smp.sample_valid), 64'(0));
        resetn = 1'b1;
        check("rclr_low0", 64'(enc_resetn), 64'(0));
        tick();
        check("rclr_low1", 64'(enc_resetn), 64'(0));
        tick();
        check("rclr_high", 64'(enc_resetn), 64'(1));
        check("rclr_no_ack", 64'(clear_ack), 64'(0));
        check("rclr_pos", 64'(smp.sample_pos), 64'(0));
        check("rclr_delta", 64'(smp.sample_delta), 64'(0));
        check("rclr_fault", 64'(smp.sample_fault), 64'(0));
        check("rclr_overrun", 64'(overrun), 64'(0));
        repeat (4) tick();
        check("idle_no_ack", 64'(clear_ack), 64'(0));
        check("idle_no_valid", 64'(smp.sample_valid), 64'(0));

        // Periodic sampling, period 9, +5 per interval
        smp.sample_ready = 1'b1;
        enc_count = 32'd5;
        push_exp(32'd5, 1'b0);
        enable = 1'b1;
        next_sample(40, n);
        check("first_latency", 64'(n), 64'(11));
        pop_cmp("per5");
        for (int k = 2; k <= 3; k++) begin
            enc_count = 32'(5 * k);
            push_exp(32'(5 * k), 1'b0);
            next_sample(40, n);
            check("per_spacing", 64'(n), 64'(10));
            pop_cmp("per");
        end

        // Wrap-around and negative delta
        enc_count = 32'hFFFF_FFFE;
        push_exp(32'hFFFF_FFFE, 1'b0);
        next_sample(40, n);
        pop_cmp("wrap_pre");
        enc_count = 32'h0000_0001;
        push_exp(32'h0000_0001, 1'b0);
        next_sample(40, n);
        pop_cmp("wrap_up");
        check("wrap_up_lit", 64'(smp.sample_delta), 64'(3));
        enc_count = 32'hFFFF_FFFF;
        push_exp(32'hFFFF_FFFF, 1'b0);
        next_sample(40, n);
        pop_cmp("wrap_neg");
        check("wrap_neg_lit", 64'(smp.sample_delta), 64'(32'hFFFF_FFFE));

        // Backpressure and overrun, period 3
        enable = 1'b0;
        tick();
        check("idle_accepted", 64'(smp.sample_valid), 64'(0));
        period = 16'd3;
        smp.sample_ready = 1'b0;
        enc_count = model_prev + 32'd4;
        push_exp(model_prev + 32'd4, 1'b0);
        enable = 1'b1;
        next_sample(40, n);
        check("bp_first_latency", 64'(n), 64'(5));
        pop_cmp("bp_first");
        enc_count = enc_count + 32'd4;
        repeat (4) tick();
        check("bp_overrun", 64'(overrun), 64'(1));
        check("bp_hold_valid", 64'(smp.sample_valid), 64'(1));
        check("bp_hold_pos", 64'(smp.sample_pos), 64'(32'd3));
        enc_count = enc_count + 32'd4;
        repeat (4) tick();
        check("bp_hold_pos2", 64'(smp.sample_pos), 64'(32'd3));
        check("bp_hold_delta2", 64'(smp.sample_delta), 64'(4));
        enc_count = enc_count + 32'd4;
        smp.sample_ready = 1'b1;
        tick();
        check("bp_accepted", 64'(smp.sample_valid), 64'(0));
        push_exp(enc_count, 1'b0);
        next_sample(40, n);
        check("bp_resume", 64'(n), 64'(3));
        pop_cmp("bp_span");
        check("bp_span_lit", 64'(smp.sample_delta), 64'(12));
        check("bp_overrun_sticky", 64'(overrun), 64'(1));

        // Requested clear in the middle of an interval
        tick();
        check("pre_clear_idle_bus", 64'(smp.sample_valid), 64'(0));
        clear_req = 1'b1;
        tick();
        check("clr_low0", 64'(enc_resetn), 64'(0));
        check("clr_overrun", 64'(overrun), 64'(0));
        check("clr_ack_early", 64'(clear_ack), 64'(0));
        enc_count = '0;
        tick();
        check("clr_low1", 64'(enc_resetn), 64'(0));
        check("clr_ack_early2", 64'(clear_ack), 64'(0));
        tick();
        check("clr_high", 64'(enc_resetn), 64'(1));
        check("clr_ack", 64'(clear_ack), 64'(1));
        clear_req  = 1'b0;
        model_prev = '0;
        enc_count  = 32'd2;
        push_exp(32'd2, 1'b0);
        tick();
        check("clr_ack_pulse", 64'(clear_ack), 64'(0));
        check("clr_stays_run", 64'(enc_resetn), 64'(1));
        next_sample(40, n);
        check("clr_cap_latency", 64'(n), 64'(3));
        pop_cmp("post_clear");

        // Fault capture, then asynchronous reset while a snapshot is pending
        enc_faultn = 1'b0;
        enc_count  = 32'd9;
        push_exp(32'd9, 1'b1);
        next_sample(40, n);
        check("fault_spacing", 64'(n), 64'(4));
        pop_cmp("fault");
        smp.sample_ready = 1'b0;
        repeat (2) tick();
        check("pend_valid", 64'(smp.sample_valid), 64'(1));
        #3;
        resetn = 1'b0;
        #1;
        check("async_valid", 64'(smp.sample_valid), 64'(0));
        check("async_enc_resetn", 64'(enc_resetn), 64'(0));
        check("async_pos", 64'(smp.sample_pos), 64'(0));
        check("async_fault", 64'(smp.sample_fault), 64'(0));
        model_prev = '0;
        tick();
        resetn     = 1'b1;
        enc_faultn = 1'b1;
        enc_count  = '0;
        check("arst_low0", 64'(enc_resetn), 64'(0));
        tick();
        check("arst_low1", 64'(enc_resetn), 64'(0));
        tick();
        check("arst_high", 64'(enc_resetn), 64'(1));
        check("arst_no_ack", 64'(clear_ack), 64'(0));
        enc_count = 32'd20;
        push_exp(32'd20, 1'b0);
        smp.sample_ready = 1'b1;
        next_sample(40, n);
        check("arst_cap_latency", 64'(n), 64'(4));
        pop_cmp("post_arst");

        check("sb_drained", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/quad_enc_sampler.md
# quad_enc_sampler

Periodic sampling controller for the quadrature decoder counter. It owns the decoder's synchronous reset, clears the count on request, and snapshots position every `period+1` clocks. Each snapshot carries position, per-interval delta (velocity) and fault status, and is handed to a downstream consumer over a valid/ready handshake. It sits between one decoder instance and the motion-control register or telemetry path.

## Interface
Parameters:
- `COUNT_W`, default 32: width of the decoder count, position and delta.
- `PERIOD_W`, default 16: width of the sample-period field.
- `CLEAR_CYCLES`, default 2: cycles `enc_resetn` is held low per clear; legal range 1..15.

Ports:
- `clk`  in  1  single clock for the whole block.
- `resetn`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level; 1 = periodic sampling active.
- `period`  in  PERIOD_W  sample interval minus one, in clk cycles.
- `clear_req`  in  1  level request to zero the decoder count and fault.
- `clear_ack`  out  1  one-cycle pulse when a requested clear completes.
- `enc_count`  in  COUNT_W  decoder count, registered in the decoder.
- `enc_faultn`  in  1  decoder fault flag, active-low, sticky until decoder reset.
- `enc_resetn`  out  1  registered synchronous reset to the decoder, active-low.
- `sample_valid`  out  1  a snapshot is presented.
- `sample_ready`  in  1  consumer accepts the snapshot.
- `sample_pos`  out  COUNT_W  captured count.
- `sample_delta`  out  COUNT_W  two's-complement count change since the last accepted capture.
- `sample_fault`  out  1  1 if `enc_faultn` was 0 at capture.
- `overrun`  out  1  sticky; a capture was dropped because the previous snapshot was not yet accepted.

## Operation
- The FSM has three states: IDLE, CLEAR and RUN.
- **Reset.** Asserting `resetn` enters CLEAR with the clear counter = CLEAR_CYCLES. Outputs reset to:
  - `enc_resetn`=0
  - `sample_valid`=0
  - `sample_pos`=0, `sample_delta`=0, `sample_fault`=0
  - `overrun`=0, `clear_ack`=0
  - `prev_pos`=0, timer=0
- **CLEAR.**
  - `enc_resetn`=0 for exactly CLEAR_CYCLES cycles, then 1.
  - Exits to RUN if `enable`=1, otherwise to IDLE.
  - `prev_pos`←0 on exit.
  - `clear_ack` pulses on the exit cycle, only if the entry was caused by `clear_req`. A reset-initiated clear gives no ack.
  - `clear_req` must be deasserted after the ack; if still high when another clear could start, a further clear is started.
- **IDLE.**
  - `enc_resetn`=1 and the timer is held.
  - `clear_req`=1 → CLEAR. `enable`=1 → RUN. If both are 1, `clear_req` wins.
- **RUN.**
  - On entry the timer loads `period`. The timer decrements each cycle; at 0 a capture occurs and the timer reloads from the current `period`. The `period` input is sampled only at load or reload.
  - Capture with `sample_valid`=0 or (`sample_valid` & `sample_ready`) in the same cycle:
    - `sample_pos`←`enc_count`
    - `sample_delta`←`enc_count`−`prev_pos` mod 2^COUNT_W
    - `sample_fault`←!`enc_faultn`
    - `prev_pos`←`enc_count`
    - `sample_valid`←1
  - Capture with `sample_valid`=1 and `sample_ready`=0: the new capture is dropped, `overrun`←1, and `prev_pos` is unchanged. The next delta therefore spans all elapsed intervals.
  - `clear_req`=1 → CLEAR (the timer restarts on return). `enable`=0 → IDLE next cycle. If both are 1, `clear_req` wins.
- **Handshake.**
  - `sample_valid`=1 & `sample_ready`=1 completes a transfer.
  - Snapshot fields are stable while `sample_valid`=1 and not accepted.
  - A pending snapshot survives transitions to IDLE and CLEAR until it is accepted.
- **Overrun.** `overrun` clears only on `resetn` or on a requested clear.

## Timing
- Capture spacing is `period`+1 cycles. `period`=0 means a capture every RUN cycle.
- First capture occurs `period`+1 cycles after the first RUN cycle.
- Capture to `sample_valid` high: 1 cycle (registered).
- `clear_req` rising in IDLE or RUN:
  - `enc_resetn` low from the next cycle, for CLEAR_CYCLES cycles.
  - `clear_ack` coincides with the first cycle `enc_resetn`=1.
- The decoder count reads 0 one cycle after the first low cycle of `enc_resetn`.
- Delta arithmetic wraps. For example, `prev_pos`=0xFFFFFFFE and `enc_count`=0x00000001 gives delta 3.
- Async reset mid-capture or mid-handshake discards the snapshot; no partial update.

## Test plan
- **Reset-clear.** Release `resetn` with `enable`=0 → `enc_resetn` low exactly 2 cycles, then 1. FSM in IDLE, no `clear_ack`, all sample outputs 0.
- **Periodic sampling.** `period`=9, `enable`=1, `sample_ready`=1, decoder driven +5 per interval → `sample_valid` pulses every 10 cycles with `sample_pos` 5, 10, 15 and `sample_delta`=5 each.
- **Wrap and negative delta.**
  - `enc_count` goes 0xFFFFFFFE → 0x00000001: `sample_delta`=3.
  - `enc_count` goes 0x00000001 → 0xFFFFFFFF: `sample_delta`=0xFFFFFFFE (−2).
- **Backpressure/overrun.** `period`=3, hold `sample_ready`=0 for 12 cycles while count climbs 4 per interval → first snapshot held stable and `overrun`=1. After accept, the next delta is 12 (three intervals).
- **Clear during RUN.** Assert `clear_req` mid-interval → `enc_resetn` low 2 cycles, `clear_ack` 1 cycle, `overrun` cleared, next capture `period`+1 cycles later with `sample_pos` equal to post-clear counts and `sample_fault`=0.
- **Fault and async reset.** Force `enc_faultn`=0 → next snapshot `sample_fault`=1. Pulse `resetn` low mid-interval with `sample_valid`=1 → `sample_valid`=0 immediately (asynchronously), then a reset-clear sequence runs.
